// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester handshake, response and APB master signals of the arbiter
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic rsp_slverr;
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic pready;
  logic pslverr;
  logic [DATA_WIDTH-1:0] prdata;
  logic busy;
  modport master (
    input req_valid, req_addr, req_write, req_wdata, pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pwdata, busy
  );
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, pready, pslverr, prdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pwdata, busy
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter sequencing NUM_REQ requesters onto one APB bus
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic pclk,
  input logic preset,
  apb_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  apb_state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, owner, g, g_nxt;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic g_write;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic arb_en, grant, done, timeout;
  assign done = state == ACCESS && bus.pready;
  assign timeout = TIMEOUT != 0 && state == ACCESS && !bus.pready && cnt == CW'(TIMEOUT - 1);
  assign arb_en = state == IDLE || done;
  assign grant = arb_en && |bus.req_valid && !preset;
  assign g_nxt = g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
  always_comb begin
    g = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) g = IW'((int'(rr_ptr) + i) % NUM_REQ);
    g_addr = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    g_write = bus.req_write[g];
    g_wdata = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    state_nxt = state == SETUP ? ACCESS : arb_en ? (grant ? SETUP : IDLE) : timeout ? IDLE : state;
    bus.req_ready = grant ? NUM_REQ'(1) << g : '0;
    bus.psel = state != IDLE;
    bus.penable = state == ACCESS;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      bus.paddr <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_slverr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state == SETUP ? '0 : state == ACCESS && !bus.pready ? cnt + 1'b1 : cnt;
      bus.rsp_valid <= done || timeout ? NUM_REQ'(1) << owner : '0;
      bus.rsp_rdata <= done && !bus.pwrite ? bus.prdata : '0;
      bus.rsp_slverr <= done ? bus.pslverr : timeout;
      if (grant) begin
        rr_ptr <= g_nxt;
        owner <= g;
        bus.paddr <= g_addr;
        bus.pwrite <= g_write;
        bus.pwdata <= g_wdata;
      end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench driving two requesters against a configurable APB slave model
module tb_apb_master_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;
  typedef struct {int r; logic [AW-1:0] a; logic w; logic [DW-1:0] d;} req_t;
  typedef struct {logic [1:0] v; logic [DW-1:0] rdata; logic err;} rsp_t;
  logic pclk = 0;
  logic preset;
  always #5 pclk = ~pclk;
  apb_master_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb_master_arbiter #(.NUM_REQ(2), .TIMEOUT(TO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk(pclk), .preset(preset), .bus(bus));
  req_t pend[$];
  rsp_t exp_q[$];
  int grant_log[$];
  int checks = 0, errors = 0, nrsp = 0, acc_n = 0, wait_cycles = 0, psel_cycles = 0, acc_cycles = 0;
  logic err_flag = 0, err_wait = 0;
  logic [DW-1:0] rd_val = 0;
  logic [AW-1:0] cur_a = 0;
  logic cur_w = 0;
  logic [DW-1:0] cur_d = 0;
  // slave: pready after wait_cycles low ACCESS cycles; noise on pready/pslverr/prdata outside ACCESS
  always @(negedge pclk) begin
    acc_n = bus.psel && bus.penable ? acc_n + 1 : 0;
    bus.pready = acc_n == 0 || acc_n > wait_cycles;
    bus.pslverr = acc_n == 0 || (bus.pready ? err_flag : err_wait);
    bus.prdata = bus.pready && acc_n != 0 ? rd_val : ~rd_val;
  end
  task automatic step();
    logic [1:0] rdy, hs;
    rsp_t e;
    for (int r = 0; r < 2; r++)
      if (!bus.req_valid[r])
        for (int i = 0; i < pend.size(); i++)
          if (pend[i].r == r) begin
            bus.req_valid[r] = 1'b1;
            bus.req_addr[r*AW +: AW] = pend[i].a;
            bus.req_write[r] = pend[i].w;
            bus.req_wdata[r*DW +: DW] = pend[i].d;
            pend.delete(i);
            break;
          end
    #6;
    rdy = bus.req_ready;
    hs = rdy & bus.req_valid;
    checks++;
    if ((rdy & ~bus.req_valid) != 0 || rdy == 2'b11) begin
      errors++;
      $display("FAIL ready_onehot got %b valid %b", rdy, bus.req_valid);
    end
    @(posedge pclk);
    #1;
    if (hs != 0) begin
      int r;
      r = hs[1] ? 1 : 0;
      cur_a = bus.req_addr[r*AW +: AW];
      cur_w = bus.req_write[r];
      cur_d = bus.req_wdata[r*DW +: DW];
      grant_log.push_back(r);
      e.v = 2'(1) << r;
      e.rdata = cur_w || wait_cycles >= TO ? '0 : rd_val;
      e.err = wait_cycles >= TO ? 1'b1 : err_flag;
      exp_q.push_back(e);
      bus.req_valid[r] = 1'b0;
    end
    if (bus.psel) begin
      psel_cycles++;
      if (bus.penable) acc_cycles++;
      checks++;
      if (bus.paddr !== cur_a || bus.pwrite !== cur_w || bus.pwdata !== cur_d) begin
        errors++;
        $display("FAIL bus_hold got %h/%b/%h expected %h/%b/%h", bus.paddr, bus.pwrite, bus.pwdata, cur_a, cur_w, cur_d);
      end
    end
    if (bus.rsp_valid != 0) begin
      nrsp++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got rsp_valid %b expected none", bus.rsp_valid);
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (bus.rsp_valid !== e.v) begin
          errors++;
          $display("FAIL rsp_valid got %b expected %b", bus.rsp_valid, e.v);
        end
        if (bus.rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata got %h expected %h", bus.rsp_rdata, e.rdata);
        end
        if (bus.rsp_slverr !== e.err) begin
          errors++;
          $display("FAIL rsp_slverr got %b expected %b", bus.rsp_slverr, e.err);
        end
      end
    end
  endtask
  task automatic run(input int max);
    int n = 0;
    while ((pend.size() != 0 || bus.req_valid != 0 || exp_q.size() != 0 || bus.busy) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL run_budget got %0d cycles expected < %0d", n, max);
    end
  endtask
  task automatic apply_reset();
    preset = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk) preset = 1'b0;
    @(posedge pclk);
    #1;
  endtask
  task automatic test_reset();
    preset = 1'b1;
    bus.req_valid = 2'b01;
    @(posedge pclk);
    #1;
    checks += 3;
    if ({bus.psel, bus.penable, bus.pwrite, bus.busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 0000", {bus.psel, bus.penable, bus.pwrite, bus.busy});
    end
    if (bus.paddr !== '0 || bus.pwdata !== '0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h expected 0/0", bus.paddr, bus.pwdata);
    end
    if (bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.rsp_rdata !== '0 || bus.rsp_slverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got %b/%b/%h/%b expected 0", bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr);
    end
    apply_reset();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy %b expected 0", bus.busy);
    end
  endtask
  task automatic test_single_read();
    int n = 0, n0 = nrsp, g0 = grant_log.size();
    wait_cycles = 0;
    err_flag = 0;
    err_wait = 0;
    rd_val = 32'hDEADBEEF;
    pend.push_back('{0, 10'h010, 1'b0, 32'h0});
    checks++;
    if (bus.psel !== 1'b0) begin
      errors++;
      $display("FAIL idle_phase got psel %b expected 0", bus.psel);
    end
    while (grant_log.size() == g0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (!(bus.psel === 1'b1 && bus.penable === 1'b0)) begin
      errors++;
      $display("FAIL setup_phase got %b%b expected 10", bus.psel, bus.penable);
    end
    step();
    checks++;
    if (!(bus.psel === 1'b1 && bus.penable === 1'b1)) begin
      errors++;
      $display("FAIL access_phase got %b%b expected 11", bus.psel, bus.penable);
    end
    step();
    checks++;
    if (nrsp != n0 + 1 || bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      errors++;
      $display("FAIL single_read_done got rsp %0d psel %b expected %0d 0", nrsp - n0, bus.psel, 1);
    end
  endtask
  task automatic test_round_robin();
    int n = 0, gaps = 0, n0, g0;
    apply_reset();
    n0 = nrsp;
    g0 = grant_log.size();
    wait_cycles = 0;
    rd_val = 32'hA5A50000;
    pend.push_back('{0, 10'h020, 1'b0, 32'h0});
    pend.push_back('{1, 10'h021, 1'b0, 32'h0});
    pend.push_back('{0, 10'h022, 1'b0, 32'h0});
    pend.push_back('{1, 10'h023, 1'b0, 32'h0});
    while (nrsp < n0 + 4 && n < 40) begin
      step();
      n++;
      if (grant_log.size() > g0 && nrsp < n0 + 4 && !bus.psel) gaps++;
    end
    checks++;
    if (grant_log.size() < g0 + 4) begin
      errors++;
      $display("FAIL rr_count got %0d grants expected 4", grant_log.size() - g0);
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[g0+i] != i % 2) begin
          errors++;
          $display("FAIL rr_order grant %0d got %0d expected %0d", i, grant_log[g0+i], i % 2);
        end
      end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL rr_no_gap got %0d idle cycles expected 0", gaps);
    end
    run(10);
  endtask
  task automatic test_wait_states();
    int n0 = nrsp;
    wait_cycles = 3;
    rd_val = 32'h5555AAAA;
    psel_cycles = 0;
    pend.push_back('{0, 10'h3FF, 1'b1, 32'h12345678});
    run(40);
    checks += 2;
    if (psel_cycles != 5) begin
      errors++;
      $display("FAIL wait_psel got %0d cycles expected 5", psel_cycles);
    end
    if (nrsp != n0 + 1) begin
      errors++;
      $display("FAIL wait_rsp got %0d responses expected 1", nrsp - n0);
    end
  endtask
  task automatic test_slave_error();
    int n0 = nrsp;
    wait_cycles = 2;
    err_flag = 1;
    err_wait = 1;
    rd_val = 32'hCAFE0001;
    pend.push_back('{1, 10'h055, 1'b0, 32'h0});
    run(40);
    err_flag = 0;
    rd_val = 32'h0BADF00D;
    pend.push_back('{0, 10'h056, 1'b0, 32'h0});
    run(40);
    err_wait = 0;
    checks++;
    if (nrsp != n0 + 2) begin
      errors++;
      $display("FAIL slverr_rsp got %0d responses expected 2", nrsp - n0);
    end
  endtask
  task automatic test_timeout();
    int n0;
    wait_cycles = 1000;
    acc_cycles = 0;
    pend.push_back('{0, 10'h100, 1'b0, 32'h0});
    run(60);
    checks++;
    if (acc_cycles != TO) begin
      errors++;
      $display("FAIL timeout_len got %0d access cycles expected %0d", acc_cycles, TO);
    end
    n0 = nrsp;
    wait_cycles = 0;
    rd_val = 32'h600D600D;
    pend.push_back('{1, 10'h101, 1'b0, 32'h0});
    run(20);
    checks++;
    if (nrsp != n0 + 1) begin
      errors++;
      $display("FAIL after_timeout got %0d responses expected 1", nrsp - n0);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0, g0;
    wait_cycles = 1000;
    pend.push_back('{0, 10'h0AA, 1'b0, 32'h0});
    while (!(bus.psel && bus.penable) && n < 10) begin
      step();
      n++;
    end
    step();
    step();
    #2;
    preset = 1'b1;
    #1;
    checks += 2;
    if ({bus.psel, bus.penable, bus.busy} !== 3'b0) begin
      errors++;
      $display("FAIL async_reset got %b expected 000", {bus.psel, bus.penable, bus.busy});
    end
    if (bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL async_reset_hs got %b/%b expected 0/0", bus.rsp_valid, bus.req_ready);
    end
    exp_q.delete();
    pend.delete();
    bus.req_valid = '0;
    @(negedge pclk) preset = 1'b0;
    @(posedge pclk);
    #1;
    wait_cycles = 0;
    rd_val = 32'h1234ABCD;
    g0 = grant_log.size();
    pend.push_back('{1, 10'h0B1, 1'b0, 32'h0});
    pend.push_back('{0, 10'h0B0, 1'b0, 32'h0});
    run(40);
    checks++;
    if (grant_log.size() != g0 + 2 || grant_log[g0] != 0 || grant_log[g0+1] != 1) begin
      errors++;
      $display("FAIL rr_after_reset got %0d grants first %0d expected 2 grants first 0", grant_log.size() - g0, grant_log.size() > g0 ? grant_log[g0] : -1);
    end
  endtask
  initial begin
    preset = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end
endmodule
